// File: rtl/popcount_arbiter_if.sv
// ---------------------------------------------------------------------------
// popcount_arbiter_if
//   Bundles the requester channel (N_REQ word offers with one-hot accept) and
//   the result channel (count + owner id) of popcount_arbiter.
//
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both high. A requester holds valid and its
//   word stable until it sees ready (it may withdraw valid instead). The
//   arbiter holds res_valid/res_count/res_id stable until res_ready is seen.
//   req_ready is a combinational function of req_valid, so requesters must
//   not derive req_valid from req_ready.
//
//   Signals
//     req_valid  N_REQ          per-requester word valid     (master -> slave)
//     req_word   N_REQ*W        requester k word at [k*W +: W] (master -> slave)
//     req_ready  N_REQ          one-hot accept               (slave -> master)
//     res_valid  1              result valid                 (slave -> master)
//     res_ready  1              result consumer ready        (master -> slave)
//     res_count  LOG_BIT_WIDTH+1 ones in the accepted word   (slave -> master)
//     res_id     ID_W           requester that owns res_count (slave -> master)
// ---------------------------------------------------------------------------
interface popcount_arbiter_if #(
  parameter int LOG_BIT_WIDTH = 5,
  parameter int N_REQ         = 4,
  parameter int ID_W          = 2
);
  localparam int W = 1 << LOG_BIT_WIDTH;

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*W-1:0]   req_word;
  logic [N_REQ-1:0]     req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [LOG_BIT_WIDTH:0] res_count;
  logic [ID_W-1:0]      res_id;

  modport master (
    output req_valid, req_word, res_ready,
    input  req_ready, res_valid, res_count, res_id
  );

  modport slave (
    input  req_valid, req_word, res_ready,
    output req_ready, res_valid, res_count, res_id
  );
endinterface

// File: rtl/popcount_arbiter.sv
// ---------------------------------------------------------------------------
// popcount_arbiter
//   Shares one ones_counter among N_REQ requesters. One word is in flight at
//   a time: a granted word is registered (IDLE/HOLD -> COUNT), counted and
//   registered as the result (COUNT -> HOLD), then held until consumed. A
//   consumed result and the next grant overlap in the same HOLD cycle.
//
//   Ports
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     bus          slave modport of popcount_arbiter_if (requests + results)
//     busy         out  high whenever the FSM is not IDLE
//     state_o      out  current FSM state (IDLE=0, COUNT=1, HOLD=2)
//
//   Build option
//     POPCOUNT_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins
//                                 undefined: round-robin from rr_ptr (default)
// ---------------------------------------------------------------------------

// Zero-extended popcount of a W-bit word using a ripple chain of adders.
module ones_counter #(
  parameter int LOG_BIT_WIDTH = 5
) (
  input  logic [(1 << LOG_BIT_WIDTH)-1:0] word_i,
  output logic [LOG_BIT_WIDTH:0]          count_o
);
  localparam int W  = 1 << LOG_BIT_WIDTH;
  localparam int CW = LOG_BIT_WIDTH + 1;

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(word_i[i]);
    end
  end
endmodule

module popcount_arbiter #(
  parameter int LOG_BIT_WIDTH = 5,
  parameter int N_REQ         = 4,
  parameter int ID_W          = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  popcount_arbiter_if.slave      bus,
  output logic                   busy,
  output logic [1:0]             state_o
);
  localparam int W     = 1 << LOG_BIT_WIDTH;
  localparam int CW    = LOG_BIT_WIDTH + 1;
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q;
  logic [W-1:0]      word_q, word_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              res_valid_q;
  logic [CW-1:0]     res_count_q;
  logic [ID_W-1:0]   res_id_q;
  logic [CW-1:0]     count;

  logic              any_req;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_open;
  logic              do_grant;

`ifndef POPCOUNT_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  // Winner selection. Round-robin scans upward from rr_ptr with wrap; the
  // fixed build scans downward so the lowest set index is the last writer.
  always_comb begin
    int idx;
    idx       = 0;
    any_req   = 1'b0;
    grant_idx = '0;
`ifdef POPCOUNT_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        any_req   = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
`else
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && bus.req_valid[idx]) begin
        any_req   = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
`endif
  end

  // A grant may only be issued when nothing is in flight: in IDLE, or in
  // HOLD while the pending result is being consumed this same edge. rst_n
  // gates it so no accept is advertised while reset is asserted.
  assign grant_open = rst_n &&
                      ((state_q == IDLE) || ((state_q == HOLD) && bus.res_ready));
  assign do_grant   = grant_open && any_req;

  assign bus.req_ready = do_grant ? (N_REQ'(1) << grant_idx) : '0;

  assign word_d = bus.req_word[grant_idx*W +: W];
  assign id_d   = ID_W'(grant_idx);

`ifndef POPCOUNT_ARB_FIXED_PRIO_EN
  assign rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
`endif

  ones_counter #(.LOG_BIT_WIDTH(LOG_BIT_WIDTH)) u_ones_counter (
    .word_i  (word_q),
    .count_o (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_id_q    <= '0;
`ifndef POPCOUNT_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      // do_grant is only ever true in IDLE or in a consuming HOLD cycle.
      if (do_grant) begin
        word_q   <= word_d;
        id_q     <= id_d;
`ifndef POPCOUNT_ARB_FIXED_PRIO_EN
        rr_ptr_q <= rr_ptr_d;
`endif
      end
      case (state_q)
        IDLE: begin
          if (do_grant) state_q <= COUNT;
        end
        COUNT: begin
          res_count_q <= count;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= do_grant ? COUNT : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_count = res_count_q;
  assign bus.res_id    = res_id_q;
  assign busy          = (state_q != IDLE);
  assign state_o       = state_q;
endmodule

// File: tb/tb_popcount_arbiter.sv
module tb_popcount_arbiter;
  localparam int LBW = 5;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = 32;
  localparam int CW  = 6;

`ifdef POPCOUNT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  popcount_arbiter_if #(.LOG_BIT_WIDTH(LBW), .N_REQ(N), .ID_W(IDW)) bus ();

  popcount_arbiter #(.LOG_BIT_WIDTH(LBW), .N_REQ(N), .ID_W(IDW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .state_o (state_dbg)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: {id, count} expected for every result, in order.
  logic [IDW+CW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got id=%0d count=%0d with nothing expected at %0t",
                 bus.res_id, bus.res_count, $time);
      end else begin
        check("sb_result", {bus.res_id, bus.res_count}, exp_q.pop_front());
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]        rv;
    logic [N-1:0][W-1:0] words;
    logic [IDW-1:0]      id;
    logic [CW-1:0]       cnt;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rv, input logic [31:0] w3, input logic [31:0] w2,
                              input logic [31:0] w1, input logic [31:0] w0,
                              input logic [1:0] id, input logic [5:0] cnt);
    vec_t v;
    v.rv    = rv;
    v.words = {w3, w2, w1, w0};
    v.id    = id;
    v.cnt   = cnt;
    return v;
  endfunction

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  // Entered and left aligned 1 time unit after a rising edge, FSM in IDLE.
  task automatic apply_vec(input vec_t v);
    bus.req_valid = v.rv;
    bus.req_word  = v.words;
    exp_q.push_back({v.id, v.cnt});
    @(negedge clk);
    check("vec_idle_state", state_dbg, 2'd0);
    check("vec_req_ready", bus.req_ready, 4'b0001 << v.id);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("vec_count_phase", {busy, bus.res_valid, bus.req_ready}, {1'b1, 1'b0, 4'b0000});
    @(posedge clk); #1;
    @(negedge clk);
    check("vec_res_valid", bus.res_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy && !bus.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [CW-1:0] ccnt[4];
    logic [IDW-1:0] cid;
    logic seen;

    // Rows 4, 6, 7 pick a different winner under fixed priority.
    vecs[0] = mk(4'b0001, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 2'd0, 6'd32);
    vecs[1] = mk(4'b0100, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 6'd0);
    vecs[2] = mk(4'b0100, 32'h0, 32'h8000_0001, 32'h0, 32'h0, 2'd2, 6'd2);
    vecs[3] = mk(4'b0011, 32'h0, 32'h0, 32'hFFFF_0000, 32'h0000_00FF, 2'd0, 6'd8);
    vecs[4] = FIXED ? mk(4'b1001, 32'hF0F0_F0F0, 32'h0, 32'h0, 32'h0000_000F, 2'd0, 6'd4)
                    : mk(4'b1001, 32'hF0F0_F0F0, 32'h0, 32'h0, 32'h0000_000F, 2'd3, 6'd16);
    vecs[5] = mk(4'b0110, 32'h0, 32'h1, 32'h1234_5678, 32'h0, 2'd1, 6'd13);
    vecs[6] = FIXED ? mk(4'b1111, 32'h7, 32'hAAAA_AAAA, 32'h3, 32'h1, 2'd0, 6'd1)
                    : mk(4'b1111, 32'h7, 32'hAAAA_AAAA, 32'h3, 32'h1, 2'd2, 6'd16);
    vecs[7] = FIXED ? mk(4'b1111, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0000_00F0, 2'd0, 6'd4)
                    : mk(4'b1111, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0000_00F0, 2'd3, 6'd31);

    // Reset with requests pending: no accept may be advertised.
    bus.req_valid = 4'b1111;
    bus.req_word  = '1;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_outputs", {busy, bus.res_valid, bus.res_count, bus.res_id, state_dbg},
          {1'b0, 1'b0, 6'd0, 2'd0, 2'd0});
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single transactions from the table.
    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);
    wait_idle();

    // Contention: all four requesting with res_ready high.
    ccnt[0] = 6'd1; ccnt[1] = 6'd2; ccnt[2] = 6'd3; ccnt[3] = 6'd4;
    bus.req_word  = {32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cid = FIXED ? 2'd0 : 2'(k % 4);
      exp_q.push_back({cid, ccnt[cid]});
      @(negedge clk);
      check("cont_grant", bus.req_ready, 4'b0001 << cid);
      @(posedge clk); #1;
      if (k == 4) bus.req_valid = '0;
      @(negedge clk);
      check("cont_count_gap", {bus.req_ready, bus.res_valid}, {4'b0000, 1'b0});
      @(posedge clk); #1;
    end
    wait_idle();

    // Backpressure: result held 5 cycles while requester 1 waits.
    bus.res_ready = 1'b0;
    bus.req_word  = {32'h0, 32'h0, 32'h0000_0003, 32'h0000_00FF};
    bus.req_valid = 4'b0001;
    exp_q.push_back({2'd0, 6'd8});
    @(negedge clk);
    check("bp_first_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("bp_count_no_ready", bus.req_ready, 4'b0000);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_stable", {bus.res_valid, bus.res_count, bus.res_id, bus.req_ready},
            {1'b1, 6'd8, 2'd0, 4'b0000});
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    exp_q.push_back({2'd1, 6'd2});
    @(negedge clk);
    check("bp_release_grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();

    // Reset while COUNT: in-flight word discarded, pointer back to 0.
    bus.req_word  = {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0003};
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("mid_rst_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    check("mid_rst_in_count", state_dbg, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", {busy, bus.res_valid, bus.req_ready, state_dbg},
          {1'b0, 1'b0, 4'b0000, 2'd0});
    bus.req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", seen, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;
    exp_q.push_back({2'd0, 6'd2});
    @(negedge clk);
    check("post_rst_ptr_zero", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
